// File: rtl/harness_run_ctrl.sv
// Run sequencer for the TestHarness: holds the DUT in reset, releases it, qualifies
// io_dut_success against a watchdog and reports pass/timeout/abort with the run length.
module harness_run_ctrl #(
  parameter int RESET_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int SUCCESS_HOLD   = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_abort,
  input  logic             io_dut_success,
  output logic             io_dut_reset,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_pass,
  output logic             io_timeout,
  output logic             io_aborted,
  output logic [CNT_W-1:0] io_cycles,
  output logic [7:0]       io_run_count
);

  localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int HOLD_W = (SUCCESS_HOLD > 1) ? $clog2(SUCCESS_HOLD) : 1;
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SUCCESS_HOLD - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RST    = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               abort_s;
  logic               pass_s;
  logic               expire_s;
  logic               start_s;
  logic               finish_s;
  logic [RST_W-1:0]   rst_cnt_r;
  logic [HOLD_W-1:0]  hold_r;
  logic [CNT_W-1:0]   cycles_r;
  logic               dut_reset_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic               timeout_r;
  logic               aborted_r;
  logic [7:0]         run_count_r;

  assign start_s  = (state_r == ST_IDLE) && (state_s == ST_RST);
  assign finish_s = (state_r != ST_FINISH) && (state_s == ST_FINISH);

  // Next-state decode; abort outranks pass, pass outranks the watchdog
  always_comb begin
    state_s  = state_r;
    abort_s  = 1'b0;
    pass_s   = 1'b0;
    expire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (io_start) state_s = ST_RST;
        else          state_s = ST_IDLE;
      end
      ST_RST: begin
        if (io_abort) begin
          abort_s = 1'b1;
          state_s = ST_FINISH;
        end else if (rst_cnt_r == RST_LAST) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_RST;
        end
      end
      ST_RUN: begin
        if (io_abort) begin
          abort_s = 1'b1;
          state_s = ST_FINISH;
        end else if (io_dut_success && (hold_r == HOLD_LAST)) begin
          pass_s  = 1'b1;
          state_s = ST_FINISH;
        end else if (cycles_r == TO_LAST) begin
          expire_s = 1'b1;
          state_s  = ST_FINISH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dut_reset_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      dut_reset_r <= (state_s != ST_RUN);
      busy_r      <= (state_s == ST_RST) || (state_s == ST_RUN);
      done_r      <= (state_s == ST_FINISH);
    end
  end

  // Reset-phase, success-hold and run-cycle counters; run cycles freeze on leaving RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_cnt_r <= {RST_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      cycles_r  <= {CNT_W{1'b0}};
    end else if (start_s) begin
      rst_cnt_r <= {RST_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      cycles_r  <= {CNT_W{1'b0}};
    end else if (state_r == ST_RST) begin
      rst_cnt_r <= rst_cnt_r + RST_W'(1);
    end else if ((state_r == ST_RUN) && (state_s == ST_RUN)) begin
      if (cycles_r != CNT_MAX) cycles_r <= cycles_r + CNT_W'(1);
      if (io_dut_success) hold_r <= hold_r + HOLD_W'(1);
      else                hold_r <= {HOLD_W{1'b0}};
    end
  end

  // Sticky result flags and completed-run counter
  always_ff @(posedge clock) begin
    if (reset) begin
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      aborted_r   <= 1'b0;
      run_count_r <= 8'd0;
    end else if (start_s) begin
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
      aborted_r <= 1'b0;
    end else if (finish_s) begin
      pass_r      <= pass_s;
      timeout_r   <= expire_s;
      aborted_r   <= abort_s;
      run_count_r <= run_count_r + 8'd1;
    end
  end

  assign io_dut_reset = dut_reset_r;
  assign io_busy      = busy_r;
  assign io_done      = done_r;
  assign io_pass      = pass_r;
  assign io_timeout   = timeout_r;
  assign io_aborted   = aborted_r;
  assign io_cycles    = cycles_r;
  assign io_run_count = run_count_r;

endmodule

// File: tb/tb_harness_run_ctrl.sv
// Self-checking bench for harness_run_ctrl: directed and randomized runs checked
// cycle by cycle against a per-run outcome model.
module tb_harness_run_ctrl;

  localparam int RC = 4;
  localparam int TO = 50;
  localparam int SH = 2;
  localparam int CW = 32;
  localparam int O_PASS = 0;
  localparam int O_TIMEOUT = 1;
  localparam int O_ABORT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_abort;
  logic          io_dut_success;
  logic          io_dut_reset;
  logic          io_busy;
  logic          io_done;
  logic          io_pass;
  logic          io_timeout;
  logic          io_aborted;
  logic [CW-1:0] io_cycles;
  logic [7:0]    io_run_count;

  int       n_cmp = 0;
  int       n_err = 0;
  bit [7:0] exp_rc = 8'd0;

  harness_run_ctrl #(
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .SUCCESS_HOLD(SH), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_abort(io_abort),
    .io_dut_success(io_dut_success), .io_dut_reset(io_dut_reset), .io_busy(io_busy),
    .io_done(io_done), .io_pass(io_pass), .io_timeout(io_timeout),
    .io_aborted(io_aborted), .io_cycles(io_cycles), .io_run_count(io_run_count)
  );

  always #5 clock = ~clock;

  // Outcome of one run from the rules: scan RUN cycles, abort first, then a success
  // streak reaching SH, then the watchdog on the last allowed cycle.
  function automatic void model(input bit [63:0] pat, input int abort_rst, input int abort_run,
                                output int outc, output int lastk);
    int streak;
    streak = 0;
    outc = O_TIMEOUT;
    lastk = TO - 1;
    if (abort_rst >= 0) begin
      outc = O_ABORT;
      lastk = -1;
      return;
    end
    for (int k = 0; k < TO; k++) begin
      if (k == abort_run) begin
        outc = O_ABORT; lastk = k; return;
      end
      streak = pat[k] ? streak + 1 : 0;
      if (streak >= SH) begin
        outc = O_PASS; lastk = k; return;
      end
    end
  endfunction

  // One complete run from IDLE back to IDLE, checked every cycle (sampled on negedge)
  task automatic do_run(input bit [63:0] pat, input int abort_rst, input int abort_run,
                        input bit rst_succ);
    int            outc;
    int            lastk;
    logic [2:0]    exp_fl;
    logic [CW-1:0] exp_cyc;
    model(pat, abort_rst, abort_run, outc, lastk);
    exp_fl  = (outc == O_PASS) ? 3'b100 : (outc == O_TIMEOUT) ? 3'b010 : 3'b001;
    exp_cyc = (lastk < 0) ? '0 : CW'(lastk);
    io_start = 1'b1; io_abort = 1'b0; io_dut_success = 1'b0;
    @(negedge clock);
    for (int r = 0; r < RC; r++) begin
      n_cmp++;
      if ({io_busy, io_dut_reset, io_done} !== 3'b110) begin
        n_err++; $display("FAIL rst_phase r=%0d busy/dut_reset/done got=%b exp=110", r, {io_busy, io_dut_reset, io_done});
      end
      if (r == 0) begin
        n_cmp++;
        if ({io_pass, io_timeout, io_aborted} !== 3'b000 || io_cycles !== '0) begin
          n_err++; $display("FAIL start_clear flags got=%b cycles got=%0d exp flags=000 cycles=0", {io_pass, io_timeout, io_aborted}, io_cycles);
        end
      end
      io_start = 1'($urandom);
      io_dut_success = rst_succ;
      io_abort = (r == abort_rst);
      @(negedge clock);
      if (r == abort_rst) break;
    end
    if (abort_rst < 0) begin
      for (int k = 0; k <= lastk; k++) begin
        n_cmp++;
        if ({io_busy, io_dut_reset, io_done} !== 3'b100 || io_cycles !== CW'(k)) begin
          n_err++; $display("FAIL run_phase k=%0d busy/dut_reset/done got=%b exp=100 cycles got=%0d exp=%0d", k, {io_busy, io_dut_reset, io_done}, io_cycles, k);
        end
        io_start = 1'($urandom);
        io_dut_success = pat[k];
        io_abort = (k == abort_run);
        @(negedge clock);
      end
    end
    io_abort = 1'b0; io_dut_success = 1'b0; io_start = 1'($urandom);
    n_cmp++;
    if ({io_busy, io_dut_reset, io_done} !== 3'b011) begin
      n_err++; $display("FAIL finish_phase busy/dut_reset/done got=%b exp=011", {io_busy, io_dut_reset, io_done});
    end
    n_cmp++;
    if ({io_pass, io_timeout, io_aborted} !== exp_fl || io_cycles !== exp_cyc) begin
      n_err++; $display("FAIL finish_result pass/timeout/aborted got=%b exp=%b cycles got=%0d exp=%0d", {io_pass, io_timeout, io_aborted}, exp_fl, io_cycles, exp_cyc);
    end
    exp_rc = exp_rc + 8'd1;
    @(negedge clock);
    io_start = 1'b0;
    n_cmp++;
    if ({io_busy, io_dut_reset, io_done} !== 3'b010 || io_run_count !== exp_rc) begin
      n_err++; $display("FAIL idle_after busy/dut_reset/done got=%b exp=010 run_count got=%0d exp=%0d", {io_busy, io_dut_reset, io_done}, io_run_count, exp_rc);
    end
    n_cmp++;
    if ({io_pass, io_timeout, io_aborted} !== exp_fl || io_cycles !== exp_cyc) begin
      n_err++; $display("FAIL result_hold flags got=%b exp=%b cycles got=%0d exp=%0d", {io_pass, io_timeout, io_aborted}, exp_fl, io_cycles, exp_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_dut_success = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({io_busy, io_dut_reset, io_done, io_pass, io_timeout, io_aborted} !== 6'b010000 ||
        io_cycles !== '0 || io_run_count !== 8'd0) begin
      n_err++; $display("FAIL reset_state outs got=%b exp=010000 cycles=%0d run_count=%0d", {io_busy, io_dut_reset, io_done, io_pass, io_timeout, io_aborted}, io_cycles, io_run_count);
    end
    reset = 1'b0;
    exp_rc = 8'd0;
    @(negedge clock);
    n_cmp++;
    if ({io_busy, io_dut_reset, io_done} !== 3'b010) begin
      n_err++; $display("FAIL idle_after_reset got=%b exp=010", {io_busy, io_dut_reset, io_done});
    end
  endtask

  task automatic test_pass();
    bit [63:0] p;
    p = ~64'd0;
    do_run(p << 10, -1, -1, 1'b0);
  endtask

  task automatic test_timeout();
    do_run(64'd0, -1, -1, 1'b0);
  endtask

  task automatic test_glitch();
    bit [63:0] p;
    p = ~64'd0;
    do_run((p << 7) | (64'd1 << 5), -1, -1, 1'b0);
  endtask

  task automatic test_rst_success_and_tie();
    do_run(64'd0, -1, -1, 1'b1);
    do_run((64'd1 << 48) | (64'd1 << 49), -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    do_run({$urandom, $urandom}, 2, -1, 1'b0);
    do_run(64'd0, -1, 7, 1'b0);
    io_abort = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (io_busy !== 1'b0 || io_aborted !== 1'b1 || io_run_count !== exp_rc) begin
        n_err++; $display("FAIL idle_abort busy got=%b aborted got=%b run_count got=%0d exp busy=0 aborted=1 run_count=%0d", io_busy, io_aborted, io_run_count, exp_rc);
      end
    end
    io_abort = 1'b0;
  endtask

  task automatic test_random();
    bit [63:0] p;
    int        ar;
    int        au;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       p = {$urandom, $urandom};
        1:       p = {$urandom, $urandom} & {$urandom, $urandom};
        default: p = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      ar = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, RC - 1)) : -1;
      au = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      do_run(p, ar, au, 1'($urandom));
    end
  endtask

  task automatic test_midrun_reset();
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0; io_dut_success = 1'b0;
    repeat (RC + 20) @(negedge clock);
    n_cmp++;
    if (io_busy !== 1'b1 || io_cycles !== CW'(20)) begin
      n_err++; $display("FAIL midrun_position busy got=%b cycles got=%0d exp busy=1 cycles=20", io_busy, io_cycles);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({io_busy, io_dut_reset, io_done, io_pass, io_timeout, io_aborted} !== 6'b010000 ||
        io_cycles !== '0 || io_run_count !== 8'd0) begin
      n_err++; $display("FAIL midrun_reset outs got=%b exp=010000 cycles=%0d run_count=%0d", {io_busy, io_dut_reset, io_done, io_pass, io_timeout, io_aborted}, io_cycles, io_run_count);
    end
    reset = 1'b0;
    exp_rc = 8'd0;
    @(negedge clock);
    n_cmp++;
    if (io_busy !== 1'b0 || io_dut_reset !== 1'b1) begin
      n_err++; $display("FAIL idle_after_midrun busy got=%b dut_reset got=%b exp 0/1", io_busy, io_dut_reset);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) do_run(64'd0, 0, -1, 1'b0);
    n_cmp++;
    if (io_run_count !== 8'd0) begin
      n_err++; $display("FAIL run_count_wrap got=%0d exp=0", io_run_count);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_glitch();
    test_rst_success_and_tie();
    test_abort();
    test_random();
    test_midrun_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
